// File: rtl/qproc_mem_loader_if.sv
// Purpose: stream and memory-port bundle between the memory loader and its surroundings.
// Latency: none, wires only.
// Backpressure: s_tready_o and m_tready_i carry the stream backpressure; the memory port has none.
// Ports: s_t* write stream into the loader, m_t* read stream out of it,
//        mem_* the PS-side memory port (sel/we/addr/w_dt driven, r_dt returned).
interface qproc_mem_loader_if;
    logic [31:0]  s_tdata_i;
    logic         s_tvalid_i;
    logic         s_tready_o;
    logic [31:0]  m_tdata_o;
    logic         m_tvalid_o;
    logic         m_tready_i;
    logic         m_tlast_o;
    logic [1:0]   mem_sel_o;
    logic         mem_we_o;
    logic [15:0]  mem_addr_o;
    logic [167:0] mem_w_dt_o;
    logic [167:0] mem_r_dt_i;

    // loader side
    modport master (
        input  s_tdata_i, s_tvalid_i, m_tready_i, mem_r_dt_i,
        output s_tready_o, m_tdata_o, m_tvalid_o, m_tlast_o,
        output mem_sel_o, mem_we_o, mem_addr_o, mem_w_dt_o
    );

    // stream source/sink and memory side
    modport slave (
        output s_tdata_i, s_tvalid_i, m_tready_i, mem_r_dt_i,
        input  s_tready_o, m_tdata_o, m_tvalid_o, m_tlast_o,
        input  mem_sel_o, mem_we_o, mem_addr_o, mem_w_dt_o
    );
endinterface

// File: rtl/qproc_mem_loader.sv
// Purpose: sequences 32-bit stream beats into pmem/dmem/wmem words and streams words back out.
// Latency: write BPW+1 cycles per word; read 1 + RD_LAT cycles per word plus BPW accepted beats.
// Backpressure: s_tready_o drops during each commit; read beats hold while m_tready_i is low.
// Ports: start_i/abort_i/dir_i/mem_sel_i/base_addr_i/len_i control a transfer,
//        busy_o/done_o/err_o report status, bus carries the streams and memory port.
module qproc_mem_loader #(
    parameter int RD_LAT = 2,
    parameter int LEN_W  = 16
) (
    input  logic             ps_clk_i,
    input  logic             ps_rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             dir_i,
    input  logic [1:0]       mem_sel_i,
    input  logic [15:0]      base_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    qproc_mem_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_COLLECT, S_WR_COMMIT, S_RD_ADDR, S_RD_WAIT, S_RD_SEND, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [15:0]        base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
    logic [2:0]         beat_cnt_q, beat_cnt_d;
    logic [2:0]         wait_cnt_q, wait_cnt_d;
    logic [167:0]       asm_q, asm_d;
    logic [167:0]       rd_q, rd_d;
    logic               err_q, err_d;
    logic [15:0]        addr_q, addr_d;

    logic [2:0]         bpw_m1;
    logic [167:0]       word_mask;
    logic               last_beat, last_word, busy;

    always_comb begin
        case (sel_q)
            2'd1:    begin bpw_m1 = 3'd2; word_mask = {96'h0, {72{1'b1}}};  end
            2'd3:    begin bpw_m1 = 3'd5; word_mask = {168{1'b1}};          end
            default: begin bpw_m1 = 3'd0; word_mask = {136'h0, {32{1'b1}}}; end
        endcase
    end

    assign last_beat = (beat_cnt_q == bpw_m1);
    assign last_word = (word_cnt_q == len_q - LEN_W'(1));
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        base_d     = base_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        asm_d      = asm_q;
        rd_d       = rd_q;
        err_d      = err_q;
        addr_d     = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sel_d      = mem_sel_i;
                    base_d     = base_addr_i;
                    len_d      = len_i;
                    word_cnt_d = '0;
                    beat_cnt_d = '0;
                    err_d      = (mem_sel_i == 2'd0);
                    if (mem_sel_i == 2'd0 || len_i == '0) begin
                        state_d = S_DONE;
                    end else if (dir_i) begin
                        addr_d  = base_addr_i;
                        state_d = S_RD_ADDR;
                    end else begin
                        state_d = S_WR_COLLECT;
                    end
                end
            end
            S_WR_COLLECT: begin
                if (bus.s_tvalid_i) begin
                    // the wmem tail beat contributes only its low byte
                    case (beat_cnt_q)
                        3'd0:    asm_d[31:0]    = bus.s_tdata_i;
                        3'd1:    asm_d[63:32]   = bus.s_tdata_i;
                        3'd2:    asm_d[95:64]   = bus.s_tdata_i;
                        3'd3:    asm_d[127:96]  = bus.s_tdata_i;
                        3'd4:    asm_d[159:128] = bus.s_tdata_i;
                        default: asm_d[167:160] = bus.s_tdata_i[7:0];
                    endcase
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        // address register moves only when a word is committed
                        addr_d     = (word_cnt_q == '0) ? base_q : addr_q + 16'd1;
                        state_d    = S_WR_COMMIT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 3'd1;
                    end
                end
            end
            S_WR_COMMIT: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + LEN_W'(1);
                    state_d    = S_WR_COLLECT;
                end
            end
            S_RD_ADDR: begin
                wait_cnt_d = 3'd1;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (int'(wait_cnt_q) >= RD_LAT) begin
                    rd_d       = bus.mem_r_dt_i & word_mask;
                    beat_cnt_d = '0;
                    state_d    = S_RD_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_RD_SEND: begin
                if (bus.m_tready_i) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        if (last_word) begin
                            state_d = S_DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + LEN_W'(1);
                            addr_d     = addr_q + 16'd1;
                            state_d    = S_RD_ADDR;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 3'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // abort overrides everything; uncommitted beats and pending reads are dropped
        if (abort_i && busy) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            addr_d  = addr_q;
        end
    end

    always_ff @(posedge ps_clk_i or negedge ps_rst_ni) begin
        if (!ps_rst_ni) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            base_q     <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            asm_q      <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            base_q     <= base_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            asm_q      <= asm_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        case (beat_cnt_q)
            3'd0:    bus.m_tdata_o = rd_q[31:0];
            3'd1:    bus.m_tdata_o = rd_q[63:32];
            3'd2:    bus.m_tdata_o = rd_q[95:64];
            3'd3:    bus.m_tdata_o = rd_q[127:96];
            3'd4:    bus.m_tdata_o = rd_q[159:128];
            default: bus.m_tdata_o = {24'h0, rd_q[167:160]};
        endcase
        if (state_q != S_RD_SEND) bus.m_tdata_o = '0;
    end

    assign busy_o         = busy;
    assign done_o         = (state_q == S_DONE);
    assign err_o          = err_q;
    assign bus.s_tready_o = (state_q == S_WR_COLLECT);
    assign bus.m_tvalid_o = (state_q == S_RD_SEND);
    assign bus.m_tlast_o  = (state_q == S_RD_SEND) && last_beat && last_word;
    assign bus.mem_sel_o  = busy ? sel_q : 2'd0;
    assign bus.mem_we_o   = (state_q == S_WR_COMMIT) && !abort_i;
    assign bus.mem_addr_o = addr_q;
    assign bus.mem_w_dt_o = (state_q == S_WR_COMMIT) ? (asm_q & word_mask) : '0;

endmodule

// File: tb/tb_qproc_mem_loader.sv
module tb_qproc_mem_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, dir;
    logic [1:0]  sel;
    logic [15:0] base, len;
    logic        busy, done, err;

    int tests = 0;
    int fails = 0;

    qproc_mem_loader_if bif ();

    qproc_mem_loader #(.RD_LAT(2), .LEN_W(16)) dut (
        .ps_clk_i    (clk),
        .ps_rst_ni   (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .dir_i       (dir),
        .mem_sel_i   (sel),
        .base_addr_i (base),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .bus         (bif)
    );

    always #5 clk = ~clk;

    // memory model: word content derived from its address, returned two cycles late
    function automatic logic [167:0] memf(input logic [15:0] a);
        logic [167:0] w;
        w = '0;
        for (int k = 0; k < 5; k++) w[32*k +: 32] = {4'(k), 12'hA5C, a};
        w[167:160] = a[7:0];
        return w;
    endfunction

    logic [15:0] ap1 = '0, ap2 = '0;
    always @(posedge clk) begin
        ap1 <= bif.mem_addr_o;
        ap2 <= ap1;
    end
    assign bif.mem_r_dt_i = memf(ap2);

    // write/done monitor
    int           cyc = 0;
    int           done_n = 0;
    int           done_cyc = 0;
    logic [15:0]  we_addr[$];
    logic [167:0] we_dat[$];
    int           we_cyc[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bif.mem_we_o) begin
            we_addr.push_back(bif.mem_addr_o);
            we_dat.push_back(bif.mem_w_dt_o);
            we_cyc.push_back(cyc);
        end
        if (done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
    end

    logic [31:0] stim [0:15];

    task automatic check(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic d, input logic [1:0] s, input logic [15:0] b, input logic [15:0] l);
        dir = d; sel = s; base = b; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beats(input string tag, input int n, input int first);
        int idx = 0;
        int c = 0;
        while (idx < n && c < 200) begin
            bif.s_tdata_i  = stim[first+idx];
            bif.s_tvalid_i = 1'b1;
            if (bif.s_tready_o) idx++;
            @(negedge clk);
            c++;
        end
        bif.s_tvalid_i = 1'b0;
        check(tag, idx, n);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 200), 1'b1);
    endtask

    function automatic logic [31:0] exp_beat(input logic [15:0] a, input int k);
        return (k == 5) ? {24'h0, a[7:0]} : {4'(k), 12'hA5C, a};
    endfunction

    initial begin
        int w0, d0, nb, c;
        logic        pend, pend_last;
        logic [31:0] pend_dat;
        logic [31:0] got [0:15];
        logic        got_last [0:15];

        for (int i = 0; i < 16; i++) stim[i] = 32'h1111_1111 * (i + 1);
        rst_n = 1'b0; start = 0; abort = 0; dir = 0; sel = 0; base = 0; len = 0;
        bif.s_tdata_i = '0; bif.s_tvalid_i = 1'b0; bif.m_tready_i = 1'b0;

        // reset state
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_tready", bif.s_tready_o, 1'b0);
        check("rst_tvalid", bif.m_tvalid_o, 1'b0);
        check("rst_tlast", bif.m_tlast_o, 1'b0);
        check("rst_we", bif.mem_we_o, 1'b0);
        check("rst_sel", bif.mem_sel_o, 2'd0);
        check("rst_addr", bif.mem_addr_o, 16'h0);
        check("rst_wdt", bif.mem_w_dt_o, 168'h0);
        check("rst_tdata", bif.m_tdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // pmem write, two words, continuous valid
        w0 = we_addr.size(); d0 = done_n;
        do_start(1'b0, 2'd1, 16'h0010, 16'd2);
        check("pm_busy", busy, 1'b1);
        check("pm_sel", bif.mem_sel_o, 2'd1);
        send_beats("pm_beats", 6, 0);
        wait_idle("pm_idle");
        check("pm_we_n", we_addr.size() - w0, 2);
        check("pm_addr0", we_addr[w0], 16'h0010);
        check("pm_dat0", we_dat[w0], 168'h33_22222222_11111111);
        check("pm_addr1", we_addr[w0+1], 16'h0011);
        check("pm_dat1", we_dat[w0+1], 168'h66_55555555_44444444);
        check("pm_rate", we_cyc[w0+1] - we_cyc[w0], 4);
        check("pm_done_n", done_n - d0, 1);
        check("pm_done_cyc", done_cyc, we_cyc[w0+1] + 1);
        check("pm_err", err, 1'b0);

        // wmem read across the address wrap, toggling ready
        w0 = we_addr.size(); d0 = done_n;
        do_start(1'b1, 2'd3, 16'hFFFF, 16'd2);
        nb = 0; pend = 0; pend_dat = '0; pend_last = 0;
        for (int i = 0; i < 16; i++) begin got[i] = '0; got_last[i] = 1'b0; end
        c = 0;
        while (nb < 12 && c < 300) begin
            if (bif.m_tvalid_o && pend) begin
                check("rd_hold_dat", bif.m_tdata_o, pend_dat);
                check("rd_hold_last", bif.m_tlast_o, pend_last);
            end
            bif.m_tready_i = c[0];
            if (bif.m_tvalid_o) begin
                if (bif.m_tready_i) begin
                    got[nb] = bif.m_tdata_o; got_last[nb] = bif.m_tlast_o;
                    nb++; pend = 0;
                end else begin
                    pend = 1; pend_dat = bif.m_tdata_o; pend_last = bif.m_tlast_o;
                end
            end
            @(negedge clk);
            c++;
        end
        bif.m_tready_i = 1'b0;
        check("rd_nbeats", nb, 12);
        for (int b = 0; b < 12; b++) begin
            check($sformatf("rd_beat%0d", b), got[b], exp_beat((b < 6) ? 16'hFFFF : 16'h0000, b % 6));
            check($sformatf("rd_last%0d", b), got_last[b], (b == 11));
        end
        wait_idle("rd_idle");
        check("rd_no_we", we_addr.size() - w0, 0);
        check("rd_done_n", done_n - d0, 1);
        check("rd_addr_hold", bif.mem_addr_o, 16'h0000);

        // dmem write wrapping 0xFFFF -> 0x0000
        w0 = we_addr.size();
        do_start(1'b0, 2'd2, 16'hFFFE, 16'd3);
        send_beats("dm_beats", 3, 6);
        wait_idle("dm_idle");
        check("dm_we_n", we_addr.size() - w0, 3);
        check("dm_addr0", we_addr[w0], 16'hFFFE);
        check("dm_dat0", we_dat[w0], 168'h77777777);
        check("dm_addr1", we_addr[w0+1], 16'hFFFF);
        check("dm_dat1", we_dat[w0+1], 168'h88888888);
        check("dm_addr2", we_addr[w0+2], 16'h0000);
        check("dm_dat2", we_dat[w0+2], 168'h99999999);
        check("dm_rate", we_cyc[w0+2] - we_cyc[w0+1], 2);

        // illegal select, then empty transfer clearing err
        w0 = we_addr.size();
        do_start(1'b0, 2'd0, 16'h0020, 16'd1);
        check("ill_done", done, 1'b1);
        check("ill_err", err, 1'b1);
        check("ill_busy", busy, 1'b0);
        @(negedge clk);
        check("ill_done_gone", done, 1'b0);
        check("ill_err_sticky", err, 1'b1);
        do_start(1'b0, 2'd2, 16'h0020, 16'd0);
        check("empty_done", done, 1'b1);
        check("empty_err", err, 1'b0);
        @(negedge clk);
        check("ill_no_we", we_addr.size() - w0, 0);

        // abort a wmem write after four beats
        w0 = we_addr.size(); d0 = done_n;
        do_start(1'b0, 2'd3, 16'h0040, 16'd1);
        send_beats("ab_beats", 4, 0);
        check("ab_busy_pre", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", busy, 1'b0);
        check("ab_err", err, 1'b1);
        check("ab_tready", bif.s_tready_o, 1'b0);
        repeat (10) @(negedge clk);
        check("ab_no_we", we_addr.size() - w0, 0);
        check("ab_no_done", done_n - d0, 0);
        check("ab_idle_busy", busy, 1'b0);

        // start while busy is ignored
        d0 = done_n;
        do_start(1'b1, 2'd2, 16'h0100, 16'd2);
        check("rs_err_clr", err, 1'b0);
        do_start(1'b0, 2'd3, 16'h0200, 16'd5);
        check("rs_sel", bif.mem_sel_o, 2'd2);
        nb = 0; c = 0;
        bif.m_tready_i = 1'b1;
        while (!done && c < 100) begin
            if (bif.m_tvalid_o && nb < 16) begin
                got[nb] = bif.m_tdata_o; got_last[nb] = bif.m_tlast_o; nb++;
            end
            @(negedge clk);
            c++;
        end
        bif.m_tready_i = 1'b0;
        check("rs_nbeats", nb, 2);
        check("rs_beat0", got[0], exp_beat(16'h0100, 0));
        check("rs_beat1", got[1], exp_beat(16'h0101, 0));
        check("rs_last0", got_last[0], 1'b0);
        check("rs_last1", got_last[1], 1'b1);
        wait_idle("rs_idle");
        check("rs_done_n", done_n - d0, 1);

        // asynchronous reset in the middle of a read
        do_start(1'b1, 2'd3, 16'h0300, 16'd2);
        c = 0;
        while (!bif.m_tvalid_o && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("ar_tvalid_pre", bif.m_tvalid_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_tvalid", bif.m_tvalid_o, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_err", err, 1'b0);
        check("ar_sel", bif.mem_sel_o, 2'd0);
        check("ar_addr", bif.mem_addr_o, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_stay_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/qproc_mem_loader.md
Name: qproc_mem_loader

Overview:
- Sequencer for the processor's PS-side memory port (program, data and waveform memories) in the ps_clk domain.
- Moves 32-bit AXI-Stream beats into 72-bit pmem, 32-bit dmem or 168-bit wmem words, and streams memory words back out.
- Owns the mem_sel/we/addr/w_dt/r_dt bus and replaces word-by-word PS register pokes.

Parameters:
- RD_LAT, 2, cycles from mem_addr_o valid to mem_r_dt_i valid; legal range 1-4.
- LEN_W, 16, width of the transfer length.

Ports:
- ps_clk_i  in  1  clock
- ps_rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  single-cycle start pulse; sampled only in IDLE
- abort_i  in  1  cancels the current transfer
- dir_i  in  1  0 = stream-to-memory (write), 1 = memory-to-stream (read)
- mem_sel_i  in  2  1 = pmem, 2 = dmem, 3 = wmem, 0 = illegal
- base_addr_i  in  16  first memory word address
- len_i  in  LEN_W  number of memory words to transfer
- busy_o  out  1  high from the cycle after an accepted start until DONE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag; cleared by the next accepted start
- s_tdata_i  in  32  write data stream
- s_tvalid_i  in  1  write data valid
- s_tready_o  out  1  write data ready
- m_tdata_o  out  32  read data stream
- m_tvalid_o  out  1  read data valid
- m_tready_i  in  1  read data ready
- m_tlast_o  out  1  marks the final beat of the transfer
- mem_sel_o  out  2  memory select to the memory port
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  16  memory address
- mem_w_dt_o  out  168  memory write data
- mem_r_dt_i  in  168  memory read data

Behaviour:
- Reset: every output is 0; FSM in IDLE.
- Inputs are latched on an accepted start: dir, sel, base, len.
- Beats per word (BPW): pmem 3, dmem 1, wmem 6.
- Packing: beats are ordered LSB first. Beat k carries bits [32k+31:32k]. The last beat of pmem uses only bits [7:0], giving bits 71:64; the last beat of wmem likewise gives bits 167:160.
- Discarded write bits: upper bits of a partial last beat are ignored.
- Read bits: upper bits of a partial last beat are driven as 0; mem_w_dt_o bits above the word width are 0.
- Address: word i uses addr = (base + i) mod 2^16; wrap at 0xFFFF -> 0x0000 is silent.
- mem_sel_o holds the latched sel while busy and is 0 otherwise.
- FSM states: IDLE, WR_COLLECT, WR_COMMIT, RD_ADDR, RD_WAIT, RD_SEND, DONE.
- IDLE:
  - start with sel = 0 -> DONE, err = 1, no memory access.
  - start with len = 0 -> DONE, err = 0, no memory access.
  - Otherwise -> WR_COLLECT or RD_ADDR according to dir.
- WR_COLLECT:
  - s_tready_o = 1; each s_tvalid & s_tready handshake stores one beat into a 168-bit assembly register.
  - After BPW beats -> WR_COMMIT.
- WR_COMMIT:
  - mem_we_o = 1 for exactly one cycle with addr and data; s_tready_o = 0.
  - Then -> WR_COLLECT, or -> DONE after word len-1.
  - Throughput: BPW+1 cycles per word with continuous valid.
- RD_ADDR: drive mem_addr_o for one cycle -> RD_WAIT.
- RD_WAIT: count RD_LAT-1 further cycles, capture mem_r_dt_i on the RD_LAT-th cycle after RD_ADDR -> RD_SEND.
- RD_SEND:
  - m_tvalid_o = 1 with beat k of the captured word.
  - m_tdata_o and m_tlast_o are held stable while m_tready_i = 0.
  - m_tlast_o = 1 only on the last beat of the last word.
  - After BPW accepted beats -> RD_ADDR for the next word, or -> DONE.
- mem_we_o is never asserted in read mode; mem_addr_o holds its last value outside RD_ADDR and WR_COMMIT.
- DONE: done_o = 1 and busy_o = 0 for one cycle, then -> IDLE.
- abort_i while busy:
  - -> IDLE next cycle, err = 1, no done_o.
  - Beats already accepted but not committed are dropped; mem_we_o is 0 from the abort cycle onward.
  - m_tvalid_o drops even if a beat is pending.
- abort_i in IDLE or DONE is ignored.
- Simultaneous start and abort in IDLE: start wins.
- start while busy: ignored; latched parameters are unchanged.
- Asynchronous reset mid-transfer: every output returns to 0 immediately and err is cleared.

Test Plan:
- pmem write: sel=1, base=0x0010, len=2, six beats 0x11111111..0x66666666 with continuous valid -> we pulses at addr 0x0010 with data 0x33_22222222_11111111 and at 0x0011 with 0x66_55555555_44444444; done 1 cycle after the second commit; err=0.
- wmem read with backpressure: sel=3, dir=1, base=0xFFFF, len=2, RD_LAT=2, m_tready toggling -> addresses 0xFFFF then 0x0000; 12 beats; beat 5 = {24'h0, bits 167:160}; data held stable while ready is low; tlast only on beat 12.
- dmem write at wrap: base=0xFFFE, len=3 -> we at 0xFFFE, 0xFFFF, 0x0000, each one cycle with the matching 32-bit beat in bits 31:0.
- Illegal and empty transfers: sel=0 -> done with err=1 and no we; len=0, sel=2 -> done with err=0 and no we; a following legal start clears err.
- Abort: wmem write, abort after 4 beats -> no we ever; busy=0 next cycle; err=1; done never pulses.
- Restart: start pulsed while busy is ignored, with latched len/base unchanged; reset asserted mid-read -> m_tvalid, busy and err go to 0 asynchronously.
